ptmch_seq: RTL and testbench

Measurement-window sequencer for the pattern-match counting path, in the CLK100M domain. It sits between the register block and the event counters. It turns software start/stop/clear commands into counter clear, count-enable and snapshot strobes. It optionally holds the window open until the first matching trigger arrives, and runs timed or manual windows. Status and elapsed-cycle outputs feed back to the register block for readout.

---
 rtl/ptmch_seq.sv | 133 +++++++++++++
 tb/tb_ptmch_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ptmch_seq.sv
// ptmch_seq - measurement-window sequencer for the pattern-match counting path.
//
// Turns one-cycle software commands into counter clear / count-enable /
// snapshot strobes, optionally waits for a selected trigger before opening the
// window, and runs either timed (CFG_WINDOW cycles) or manual (stop-terminated)
// windows. All logic is in the CLK100M domain.
//
// Ports
//   CLK100M, RESET          clock, synchronous active-high reset
//   CTRL_START/STOP/CLEAR   one-cycle commands, priority CLEAR > STOP > START
//   CFG_MODE                0 = timed window, 1 = manual
//   CFG_TRGSTART            1 = hold in ARMED until a selected trigger hits
//   CFG_TRGSEL              trigger channel mask for arming
//   CFG_WINDOW              timed window length (0 behaves as 1)
//   TRG_PLS                 synchronous trigger pulses
//   CNT_CLR, CNT_EN, SNAP   counter clear, gate and capture strobes
//   IRQ                     one-cycle window-complete pulse
//   STAT_STATE/BUSY/DONE    status for register readout
//   ELAPSED                 enabled cycles in current / last window
//   WINCNT                  completed windows since reset (wrapping)

module ptmch_seq #(
  parameter int P_WIN_W  = 32,
  parameter int P_WCNT_W = 16
) (
  input  logic                CLK100M,
  input  logic                RESET,
  input  logic                CTRL_START,
  input  logic                CTRL_STOP,
  input  logic                CTRL_CLEAR,
  input  logic                CFG_MODE,
  input  logic                CFG_TRGSTART,
  input  logic [4:0]          CFG_TRGSEL,
  input  logic [P_WIN_W-1:0]  CFG_WINDOW,
  input  logic [4:0]          TRG_PLS,
  output logic                CNT_CLR,
  output logic                CNT_EN,
  output logic                SNAP,
  output logic                IRQ,
  output logic [2:0]          STAT_STATE,
  output logic                STAT_BUSY,
  output logic                STAT_DONE,
  output logic [P_WIN_W-1:0]  ELAPSED,
  output logic [P_WCNT_W-1:0] WINCNT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_SNAP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [P_WIN_W-1:0]  WIN_ONE  = P_WIN_W'(1);
  localparam logic [P_WCNT_W-1:0] WCNT_ONE = P_WCNT_W'(1);

  logic [2:0]          state, state_nxt;
  logic                clr_pend;     // CTRL_CLEAR seen last cycle -> CNT_CLR now
  logic [P_WIN_W-1:0]  elapsed_q, elapsed_inc, win_max;
  logic [P_WCNT_W-1:0] wincnt_q;
  logic                hit, win_end, cnt_en_c;

  assign hit         = |(TRG_PLS & CFG_TRGSEL);
  assign win_max     = (CFG_WINDOW == '0) ? WIN_ONE : CFG_WINDOW;
  // Saturating increment; only manual mode can actually reach all-ones.
  assign elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + WIN_ONE;
  // Window closes in the cycle whose increment reaches the length.
  assign win_end     = !CFG_MODE && (elapsed_inc >= win_max);

  // State register
  always_ff @(posedge CLK100M) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (CTRL_CLEAR) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        // STOP is ignored here but still outranks a simultaneous START.
        S_IDLE:  if (CTRL_START && !CTRL_STOP) state_nxt = S_CLEAR;
        S_CLEAR: state_nxt = CFG_TRGSTART ? S_ARMED : S_RUN;
        S_ARMED: begin
          if (CTRL_STOP)  state_nxt = S_IDLE;
          // A one-cycle timed window is fully spent by the arming cycle.
          else if (hit)   state_nxt = win_end ? S_SNAP : S_RUN;
        end
        S_RUN:   if (CTRL_STOP || win_end) state_nxt = S_SNAP;
        S_SNAP:  state_nxt = S_DONE;
        S_DONE:  if (CTRL_START && !CTRL_STOP) state_nxt = S_CLEAR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    cnt_en_c = 1'b0;
    if (!CTRL_CLEAR && !CTRL_STOP) begin
      if (state == S_RUN)   cnt_en_c = 1'b1;
      if (state == S_ARMED) cnt_en_c = hit;
    end
    CNT_EN     = cnt_en_c;
    CNT_CLR    = (state == S_CLEAR) || clr_pend;
    SNAP       = (state == S_SNAP);
    IRQ        = (state == S_SNAP);
    STAT_STATE = state;
    STAT_BUSY  = (state == S_CLEAR) || (state == S_ARMED) ||
                 (state == S_RUN)   || (state == S_SNAP);
    STAT_DONE  = (state == S_DONE);
  end

  // Elapsed / window counters
  always_ff @(posedge CLK100M) begin
    if (RESET) begin
      clr_pend  <= 1'b0;
      elapsed_q <= '0;
      wincnt_q  <= '0;
    end else begin
      clr_pend <= CTRL_CLEAR;
      if (CTRL_CLEAR || state == S_CLEAR) elapsed_q <= '0;
      else if (cnt_en_c)                  elapsed_q <= elapsed_inc;
      if (state == S_SNAP) wincnt_q <= wincnt_q + WCNT_ONE;
    end
  end

  assign ELAPSED = elapsed_q;
  assign WINCNT  = wincnt_q;

endmodule

// File: tb/tb_ptmch_seq.sv
// Self-checking bench for ptmch_seq. Stimulus pushes the expected window
// result into a scoreboard; a negedge monitor pops it on every SNAP strobe.
// WINCNT is instantiated 8 bits wide so the wrap case stays short.

module tb_ptmch_seq;
  localparam int WW = 32;
  localparam int CW = 8;

  logic          CLK100M = 1'b0;
  logic          RESET = 1'b1;
  logic          CTRL_START = 1'b0, CTRL_STOP = 1'b0, CTRL_CLEAR = 1'b0;
  logic          CFG_MODE = 1'b0, CFG_TRGSTART = 1'b0;
  logic [4:0]    CFG_TRGSEL = '0, TRG_PLS = '0;
  logic [WW-1:0] CFG_WINDOW = '0;
  logic          CNT_CLR, CNT_EN, SNAP, IRQ, STAT_BUSY, STAT_DONE;
  logic [2:0]    STAT_STATE;
  logic [WW-1:0] ELAPSED;
  logic [CW-1:0] WINCNT;

  ptmch_seq #(.P_WIN_W(WW), .P_WCNT_W(CW)) dut (
    .CLK100M(CLK100M), .RESET(RESET),
    .CTRL_START(CTRL_START), .CTRL_STOP(CTRL_STOP), .CTRL_CLEAR(CTRL_CLEAR),
    .CFG_MODE(CFG_MODE), .CFG_TRGSTART(CFG_TRGSTART), .CFG_TRGSEL(CFG_TRGSEL),
    .CFG_WINDOW(CFG_WINDOW), .TRG_PLS(TRG_PLS),
    .CNT_CLR(CNT_CLR), .CNT_EN(CNT_EN), .SNAP(SNAP), .IRQ(IRQ),
    .STAT_STATE(STAT_STATE), .STAT_BUSY(STAT_BUSY), .STAT_DONE(STAT_DONE),
    .ELAPSED(ELAPSED), .WINCNT(WINCNT)
  );

  always #5 CLK100M = ~CLK100M;

  int cyc = 0;
  always @(posedge CLK100M) cyc <= cyc + 1;

  typedef struct {
    int            snap_cyc;
    int            clr_cyc;
    int            en_first;
    int            en_cnt;
    logic [WW-1:0] elapsed;
    logic [CW-1:0] wincnt;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0, n_fail = 0;
  logic [CW-1:0] exp_wcnt = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: tracks enable activity since the last CNT_CLR, checks on SNAP.
  int mon_en_first = -1, mon_en_cnt = 0, mon_clr_cyc = -1;
  always @(negedge CLK100M) begin : monitor
    exp_t e;
    if (!RESET) begin
      if (CNT_CLR) begin
        mon_en_first = -1;
        mon_en_cnt   = 0;
        mon_clr_cyc  = cyc;
      end
      if (CNT_EN) begin
        if (mon_en_first < 0) mon_en_first = cyc;
        mon_en_cnt++;
      end
      if (SNAP || IRQ) chk("irq_with_snap", IRQ, SNAP);
      if (SNAP) begin
        if (sb.size() == 0) begin
          chk("unexpected_snap", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("snap_cycle", cyc, e.snap_cyc);
          chk("clr_cycle", mon_clr_cyc, e.clr_cyc);
          chk("en_first", mon_en_first, e.en_first);
          chk("en_count", mon_en_cnt, e.en_cnt);
          chk("snap_elapsed", ELAPSED, e.elapsed);
          chk("snap_wincnt", WINCNT, e.wincnt);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK100M); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic cmd(input logic s, input logic p, input logic c, output int t);
    CTRL_START = s; CTRL_STOP = p; CTRL_CLEAR = c;
    t = cyc;
    step();
    CTRL_START = 1'b0; CTRL_STOP = 1'b0; CTRL_CLEAR = 1'b0;
  endtask

  task automatic push(input int snap_c, input int clr_c, input int ef, input int ec,
                      input int el);
    exp_t e;
    e.snap_cyc = snap_c; e.clr_cyc = clr_c; e.en_first = ef; e.en_cnt = ec;
    e.elapsed = WW'(el); e.wincnt = exp_wcnt;
    sb.push_back(e);
    exp_wcnt = exp_wcnt + 1'b1;
  endtask

  task automatic timed_window(input int w);
    int t, eff;
    eff = (w == 0) ? 1 : w;
    CFG_MODE = 1'b0; CFG_TRGSTART = 1'b0; CFG_WINDOW = WW'(w);
    cmd(1'b1, 1'b0, 1'b0, t);
    push(t + 2 + eff, t + 1, t + 2, eff, eff);
    wait_until(t + 3 + eff);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, STAT_STATE, 0);
    chk({tag, "_cnt_clr"}, CNT_CLR, 0);
    chk({tag, "_cnt_en"}, CNT_EN, 0);
    chk({tag, "_snap"}, SNAP, 0);
    chk({tag, "_irq"}, IRQ, 0);
    chk({tag, "_busy"}, STAT_BUSY, 0);
    chk({tag, "_done"}, STAT_DONE, 0);
    chk({tag, "_elapsed"}, ELAPSED, 0);
    chk({tag, "_wincnt"}, WINCNT, 0);
  endtask

  initial begin : stim
    int t, h;
    repeat (3) step();
    chk_reset_outputs("reset");
    RESET = 1'b0;
    step();

    // Timed W=10, no arming
    timed_window(10);
    chk("t1_done", STAT_DONE, 1);
    chk("t1_state", STAT_STATE, 5);
    chk("t1_elapsed", ELAPSED, 10);
    chk("t1_wincnt", WINCNT, 1);

    // Arm on ch2; a ch0 pulse must not arm
    CFG_MODE = 1'b0; CFG_TRGSTART = 1'b1; CFG_TRGSEL = 5'b00100; CFG_WINDOW = 4;
    cmd(1'b1, 1'b0, 1'b0, t);
    wait_until(t + 4);
    TRG_PLS = 5'b00001; step(); TRG_PLS = '0;
    wait_until(t + 8);
    chk("t2_still_armed", STAT_STATE, 2);
    h = cyc;
    push(h + 4, t + 1, h, 4, 4);
    TRG_PLS = 5'b00100; step(); TRG_PLS = '0;
    wait_until(h + 5);
    chk("t2_done", STAT_DONE, 1);
    chk("t2_elapsed", ELAPSED, 4);

    // Manual, STOP 50 cycles into RUN
    CFG_MODE = 1'b1; CFG_TRGSTART = 1'b0;
    cmd(1'b1, 1'b0, 1'b0, t);
    wait_until(t + 52);
    push(t + 53, t + 1, t + 2, 50, 50);
    cmd(1'b0, 1'b1, 1'b0, h);
    wait_until(t + 54);
    chk("t3_done", STAT_DONE, 1);
    chk("t3_elapsed", ELAPSED, 50);

    // STOP while ARMED -> IDLE, no SNAP
    CFG_TRGSTART = 1'b1; CFG_TRGSEL = 5'b00100;
    cmd(1'b1, 1'b0, 1'b0, t);
    wait_until(t + 3);
    chk("t3b_armed", STAT_STATE, 2);
    cmd(1'b0, 1'b1, 1'b0, h);
    chk("t3b_idle", STAT_STATE, 0);
    chk("t3b_wincnt", WINCNT, exp_wcnt);

    // START+STOP+CLEAR during RUN -> IDLE with CNT_CLR pulse
    CFG_TRGSTART = 1'b0;
    cmd(1'b1, 1'b0, 1'b0, t);
    wait_until(t + 5);
    chk("t4_run", STAT_STATE, 3);
    cmd(1'b1, 1'b1, 1'b1, h);
    chk("t4_idle", STAT_STATE, 0);
    chk("t4_cnt_clr", CNT_CLR, 1);
    chk("t4_elapsed", ELAPSED, 0);
    step();
    chk("t4_cnt_clr_off", CNT_CLR, 0);
    // START+STOP in IDLE -> stays IDLE
    cmd(1'b1, 1'b1, 1'b0, h);
    chk("t4b_idle", STAT_STATE, 0);
    chk("t4b_busy", STAT_BUSY, 0);

    // CFG_WINDOW=0 gives one enable cycle
    timed_window(0);
    chk("t5_elapsed", ELAPSED, 1);

    // RESET at ELAPSED=3 of W=10
    CFG_WINDOW = 10;
    cmd(1'b1, 1'b0, 1'b0, t);
    wait_until(t + 5);
    chk("t5b_elapsed3", ELAPSED, 3);
    RESET = 1'b1;
    step();
    chk_reset_outputs("midreset");
    exp_wcnt = '0;
    RESET = 1'b0;
    repeat (3) step();
    chk("t5b_idle", STAT_STATE, 0);

    // WINCNT wrap: 253 preload windows then 3 rearms from DONE
    repeat (253) timed_window(1);
    chk("t6_preload", WINCNT, 253);
    repeat (3) timed_window(1);
    chk("t6_wrap", WINCNT, 0);
    chk("t6_done", STAT_DONE, 1);

    repeat (5) step();
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
